// File: rtl/ddr_rd_sched_if.sv
// Burst read-request and read-data channels between the DDR read scheduler and the AXI read master.
// master: scheduler side (issues requests, sinks beats); slave: memory side.
interface ddr_rd_sched_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned LEN_WIDTH  = 8
);
  logic                  rd_req_valid;
  logic                  rd_req_ready;
  logic [ADDR_WIDTH-1:0] rd_req_addr;
  logic [LEN_WIDTH-1:0]  rd_req_len;
  logic                  rd_data_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_data_last;

  modport master (
    output rd_req_valid, rd_req_addr, rd_req_len,
    input  rd_req_ready, rd_data_valid, rd_data, rd_data_last
  );

  modport slave (
    input  rd_req_valid, rd_req_addr, rd_req_len,
    output rd_req_ready, rd_data_valid, rd_data, rd_data_last
  );
endinterface

// File: rtl/ddr_rd_sched.sv
// DDR read scheduler: fetches the layer-config word, then arbitrates four streams onto one burst port.
// Define DDR_RD_SCHED_RR_EN for round-robin arbitration; default is fixed priority (ACT highest).
module ddr_rd_sched #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [ADDR_WIDTH-1:0] act_base,
  input  logic [ADDR_WIDTH-1:0] flgact_base,
  input  logic [ADDR_WIDTH-1:0] wei_base,
  input  logic [ADDR_WIDTH-1:0] flgwei_base,
  input  logic [3:0]            req_vld,
  output logic [3:0]            req_gnt,
  ddr_rd_sched_if.master        ddr,
  output logic [3:0]            out_vld,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [DATA_WIDTH-1:0] cfg_word,
  output logic                  cfg_vld,
  output logic                  busy,
  output logic                  err
);

  localparam int unsigned BurstBytes = BURST_LEN * DATA_WIDTH / 8;
  localparam int unsigned CntWidth   = $clog2(BURST_LEN + 1);

  typedef enum logic [2:0] {StIdle, StCfgReq, StCfgWait, StArb, StReq, StData} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] base_q   [4];
  logic [ADDR_WIDTH-1:0] cursor_q [4];
  logic [1:0]            win_q;
  logic [CntWidth-1:0]   beat_cnt_q;
  logic                  rd_req_valid_q;
  logic [ADDR_WIDTH-1:0] rd_req_addr_q;
  logic [LEN_WIDTH-1:0]  rd_req_len_q;
  logic [3:0]            req_gnt_q;
  logic [3:0]            out_vld_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [DATA_WIDTH-1:0] cfg_word_q;
  logic                  cfg_vld_q;
  logic                  err_q;

  logic [1:0] win_d;
  logic [1:0] idx;
  logic       final_beat;

`ifdef DDR_RD_SCHED_RR_EN
  logic [1:0] rr_ptr_q;
`endif

  // Scan from the highest offset down so the lowest requesting offset is assigned last and wins.
  always_comb begin
    win_d = 2'd0;
    idx   = 2'd0;
    for (int k = 3; k >= 0; k--) begin
`ifdef DDR_RD_SCHED_RR_EN
      idx = rr_ptr_q + 2'(k);
`else
      idx = 2'(k);
`endif
      if (req_vld[idx]) begin
        win_d = idx;
      end
    end
  end

  assign final_beat = (beat_cnt_q == CntWidth'(BURST_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      for (int i = 0; i < 4; i++) begin
        base_q[i]   <= '0;
        cursor_q[i] <= '0;
      end
      win_q          <= '0;
      beat_cnt_q     <= '0;
      rd_req_valid_q <= 1'b0;
      rd_req_addr_q  <= '0;
      rd_req_len_q   <= '0;
      req_gnt_q      <= '0;
      out_vld_q      <= '0;
      out_data_q     <= '0;
      cfg_word_q     <= '0;
      cfg_vld_q      <= 1'b0;
      err_q          <= 1'b0;
`ifdef DDR_RD_SCHED_RR_EN
      rr_ptr_q       <= '0;
`endif
    end else begin
      req_gnt_q <= '0;
      out_vld_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            base_q[0] <= act_base;
            base_q[1] <= flgact_base;
            base_q[2] <= wei_base;
            base_q[3] <= flgwei_base;
            for (int i = 0; i < 4; i++) begin
              cursor_q[i] <= '0;
            end
            cfg_vld_q      <= 1'b0;
            err_q          <= 1'b0;
            rd_req_valid_q <= 1'b1;
            rd_req_addr_q  <= cfg_base;
            rd_req_len_q   <= '0;
            state_q        <= StCfgReq;
          end
        end
        StCfgReq: begin
          if (ddr.rd_req_ready) begin
            rd_req_valid_q <= 1'b0;
            state_q        <= StCfgWait;
          end
        end
        StCfgWait: begin
          if (ddr.rd_data_valid) begin
            cfg_word_q <= ddr.rd_data;
            cfg_vld_q  <= 1'b1;
            if (!ddr.rd_data_last) begin
              err_q <= 1'b1;
            end
            state_q <= StArb;
          end
        end
        StArb: begin
          if (|req_vld) begin
            win_q          <= win_d;
            rd_req_addr_q  <= base_q[win_d] + cursor_q[win_d];
            rd_req_len_q   <= LEN_WIDTH'(BURST_LEN - 1);
            rd_req_valid_q <= 1'b1;
            state_q        <= StReq;
          end
        end
        StReq: begin
          if (ddr.rd_req_ready) begin
            rd_req_valid_q  <= 1'b0;
            req_gnt_q       <= 4'b0001 << win_q;
            cursor_q[win_q] <= cursor_q[win_q] + ADDR_WIDTH'(BurstBytes);
            beat_cnt_q      <= '0;
`ifdef DDR_RD_SCHED_RR_EN
            rr_ptr_q        <= win_q + 2'd1;
`endif
            state_q         <= StData;
          end
        end
        StData: begin
          if (ddr.rd_data_valid) begin
            out_vld_q  <= 4'b0001 << win_q;
            out_data_q <= ddr.rd_data;
            beat_cnt_q <= beat_cnt_q + 1'b1;
            // A last marker that disagrees with the beat count ends the burst early and flags it.
            if (ddr.rd_data_last != final_beat) begin
              err_q <= 1'b1;
            end
            if (ddr.rd_data_last || final_beat) begin
              state_q <= StArb;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ddr.rd_req_valid = rd_req_valid_q;
  assign ddr.rd_req_addr  = rd_req_addr_q;
  assign ddr.rd_req_len   = rd_req_len_q;
  assign req_gnt          = req_gnt_q;
  assign out_vld          = out_vld_q;
  assign out_data         = out_data_q;
  assign cfg_word         = cfg_word_q;
  assign cfg_vld          = cfg_vld_q;
  assign err              = err_q;
  assign busy             = (state_q != StIdle);

endmodule

// File: tb/tb_ddr_rd_sched.sv
// Bench for ddr_rd_sched: randomized DDR responder, transaction-level reference model compared every
// cycle, plus directed literal checks for config fetch, single stream, contention, backpressure, errors.
module tb_ddr_rd_sched;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 128;
  localparam int unsigned BL = 16;
  localparam int unsigned LW = 8;
  localparam logic [31:0] BB = 32'h100;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   cfg_base, act_base, flgact_base, wei_base, flgwei_base;
  logic [3:0]    req_vld = 4'b0;
  logic [3:0]    req_gnt, out_vld;
  logic [127:0]  out_data, cfg_word;
  logic          cfg_vld, busy, err;

  ddr_rd_sched_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) ddr ();

  ddr_rd_sched #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL), .LEN_WIDTH(LW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cfg_base   (cfg_base),
    .act_base   (act_base),
    .flgact_base(flgact_base),
    .wei_base   (wei_base),
    .flgwei_base(flgwei_base),
    .req_vld    (req_vld),
    .req_gnt    (req_gnt),
    .ddr        (ddr),
    .out_vld    (out_vld),
    .out_data   (out_data),
    .cfg_word   (cfg_word),
    .cfg_vld    (cfg_vld),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- responder controls and logs ----------------
  bit           hold_ready = 1'b0;
  int           err_mode = 0;      // 0 clean, 1 last at beat 10, 2 no last on final beat
  logic [127:0] cfg_data = 128'h7BEF5;
  logic [31:0]  hs_log[$];
  logic [3:0]   gnt_log[$];
  int           beats[4];

  initial begin
    bit          hs;
    logic [7:0]  hs_len;
    logic [31:0] hs_addr;
    int          left, sent, cur_mode;
    bit          is_cfg;
    left = 0; sent = 0; cur_mode = 0; is_cfg = 1'b0;
    ddr.rd_req_ready  = 1'b0;
    ddr.rd_data_valid = 1'b0;
    ddr.rd_data       = '0;
    ddr.rd_data_last  = 1'b0;
    forever begin
      @(posedge clk);
      hs      = ddr.rd_req_valid && ddr.rd_req_ready;
      hs_len  = ddr.rd_req_len;
      hs_addr = ddr.rd_req_addr;
      #1;
      ddr.rd_data_valid = 1'b0;
      ddr.rd_data_last  = 1'b0;
      if (!rst_n) begin
        left = 0;
        ddr.rd_req_ready = 1'b0;
        continue;
      end
      if (hs) begin
        hs_log.push_back(hs_addr);
        left     = int'(hs_len) + 1;
        sent     = 0;
        is_cfg   = (hs_len == 8'd0);
        cur_mode = is_cfg ? 0 : err_mode;
        if (!is_cfg) err_mode = 0;
      end
      if (left > 0) begin
        if ($urandom_range(0, 3) != 0) begin
          sent++;
          ddr.rd_data_valid = 1'b1;
          ddr.rd_data = is_cfg ? cfg_data : {$urandom, $urandom, $urandom, $urandom};
          ddr.rd_data_last = (sent == left);
          if (cur_mode == 1 && sent == 10) ddr.rd_data_last = 1'b1;
          if (cur_mode == 2 && sent == left) ddr.rd_data_last = 1'b0;
          if (ddr.rd_data_last || sent == left) left = 0;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        // Stray beat while nothing is outstanding; the scheduler must drop it.
        ddr.rd_data_valid = 1'b1;
        ddr.rd_data       = {$urandom, $urandom, $urandom, $urandom};
        ddr.rd_data_last  = 1'($urandom_range(0, 1));
      end
      ddr.rd_req_ready = hold_ready ? 1'b0 : ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (req_gnt != 4'b0) gnt_log.push_back(req_gnt);
      for (int i = 0; i < 4; i++) if (out_vld[i]) beats[i]++;
    end
  end

  // ---------------- reference model ----------------
  localparam int PhIdle = 0, PhCfgReq = 1, PhCfgWait = 2, PhArb = 3, PhReq = 4, PhData = 5;
  int           m_ph, m_w, m_rr, m_left;
  logic [31:0]  m_base[4], m_cur[4];
  logic         m_req, m_cfg_vld, m_err;
  logic [31:0]  m_addr;
  logic [7:0]   m_len;
  logic [3:0]   m_gnt, m_ovld;
  logic [127:0] m_odata, m_cfg_word;

  function automatic int pick(input logic [3:0] v, input int from);
    for (int k = 0; k < 4; k++) begin
      if (v[(from + k) % 4]) return (from + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ph = PhIdle; m_w = 0; m_rr = 0; m_left = 0;
    for (int i = 0; i < 4; i++) begin m_base[i] = '0; m_cur[i] = '0; end
    m_req = 1'b0; m_cfg_vld = 1'b0; m_err = 1'b0; m_addr = '0; m_len = '0;
    m_gnt = '0; m_ovld = '0; m_odata = '0; m_cfg_word = '0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
        continue;
      end
      m_gnt  = '0;
      m_ovld = '0;
      case (m_ph)
        PhIdle: if (start) begin
          m_base[0] = act_base; m_base[1] = flgact_base;
          m_base[2] = wei_base; m_base[3] = flgwei_base;
          for (int i = 0; i < 4; i++) m_cur[i] = '0;
          m_cfg_vld = 1'b0; m_err = 1'b0;
          m_req = 1'b1; m_addr = cfg_base; m_len = 8'd0;
          m_ph = PhCfgReq;
        end
        PhCfgReq: if (ddr.rd_req_ready) begin
          m_req = 1'b0; m_ph = PhCfgWait;
        end
        PhCfgWait: if (ddr.rd_data_valid) begin
          m_cfg_word = ddr.rd_data; m_cfg_vld = 1'b1;
          if (!ddr.rd_data_last) m_err = 1'b1;
          m_ph = PhArb;
        end
        PhArb: if (req_vld != 4'b0) begin
`ifdef DDR_RD_SCHED_RR_EN
          m_w = pick(req_vld, m_rr);
`else
          m_w = pick(req_vld, 0);
`endif
          m_addr = m_base[m_w] + m_cur[m_w];
          m_len  = 8'(BL - 1);
          m_req  = 1'b1;
          m_ph   = PhReq;
        end
        PhReq: if (ddr.rd_req_ready) begin
          m_req = 1'b0;
          m_gnt = 4'b0001 << m_w;
          m_cur[m_w] = m_cur[m_w] + BB;
          m_rr = (m_w + 1) % 4;
          m_left = BL;
          m_ph = PhData;
        end
        PhData: if (ddr.rd_data_valid) begin
          m_ovld  = 4'b0001 << m_w;
          m_odata = ddr.rd_data;
          m_left--;
          if (ddr.rd_data_last != (m_left == 0)) m_err = 1'b1;
          if (ddr.rd_data_last || m_left == 0) m_ph = PhArb;
        end
        default: m_ph = PhIdle;
      endcase
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("rd_req_valid", ddr.rd_req_valid, m_req);
      if (m_req) begin
        chk("rd_req_addr", ddr.rd_req_addr, m_addr);
        chk("rd_req_len", ddr.rd_req_len, m_len);
      end
      chk("req_gnt", req_gnt, m_gnt);
      chk("out_vld", out_vld, m_ovld);
      chk("out_data", out_data, m_odata);
      chk("cfg_vld", cfg_vld, m_cfg_vld);
      chk("cfg_word", cfg_word, m_cfg_word);
      chk("err", err, m_err);
      chk("busy", busy, m_ph != PhIdle);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic pulse_start();
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
  endtask

  function automatic bit cond(input int kind);
    case (kind)
      0: return cfg_vld;
      1: return ddr.rd_req_valid;
      2: return out_vld[0];
      3: return err;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_cond(input int kind, input string name);
    int b = 0;
    while (!cond(kind) && b < 2000) begin @(negedge clk); b++; end
    chk(name, cond(kind), 1'b1);
  endtask

  task automatic wait_gnts(input int n, input string name);
    int b = 0;
    while (gnt_log.size() < n && b < 3000) begin @(negedge clk); b++; end
    chk(name, gnt_log.size() >= n, 1'b1);
  endtask

  task automatic wait_beats(input int s, input int n, input string name);
    int b = 0;
    while (beats[s] < n && b < 3000) begin @(negedge clk); b++; end
    chk(name, beats[s] >= n, 1'b1);
  endtask

  task automatic clear_logs();
    hs_log.delete();
    gnt_log.delete();
    for (int i = 0; i < 4; i++) beats[i] = 0;
  endtask

  task automatic check_outputs_zero(input string name);
    chk({name, "_busy"}, busy, 1'b0);
    chk({name, "_req_valid"}, ddr.rd_req_valid, 1'b0);
    chk({name, "_gnt"}, req_gnt, 4'b0);
    chk({name, "_out_vld"}, out_vld, 4'b0);
    chk({name, "_out_data"}, out_data, 128'b0);
    chk({name, "_cfg_vld"}, cfg_vld, 1'b0);
    chk({name, "_cfg_word"}, cfg_word, 128'b0);
    chk({name, "_err"}, err, 1'b0);
  endtask

  logic [3:0]  exp_gnt[6];
  logic [31:0] exp_addr[6];
  logic [31:0] exp_f, exp_g0, exp_g1;

  initial begin
    cfg_base    = 32'h0800_0000;
    act_base    = 32'h0801_0000;
    flgact_base = 32'h0802_0000;
    wei_base    = 32'h0803_0000;
    flgwei_base = 32'h0804_0000;
`ifdef DDR_RD_SCHED_RR_EN
    exp_gnt  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    exp_addr = '{32'h0801_0000, 32'h0802_0000, 32'h0803_0000, 32'h0804_0000,
                 32'h0801_0100, 32'h0802_0100};
    exp_f  = 32'h0803_0100;
    exp_g0 = 32'h0801_0200;
    exp_g1 = 32'h0801_0300;
`else
    for (int k = 0; k < 6; k++) begin
      exp_gnt[k]  = 4'b0001;
      exp_addr[k] = 32'h0801_0000 + 32'(k) * BB;
    end
    exp_f  = 32'h0803_0000;
    exp_g0 = 32'h0801_0600;
    exp_g1 = 32'h0801_0700;
`endif

    // Reset state
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #3 rst_n = 1'b1;

    // Config fetch
    pulse_start();
    @(negedge clk);
    chk("cfg_req_valid", ddr.rd_req_valid, 1'b1);
    chk("cfg_req_addr", ddr.rd_req_addr, 32'h0800_0000);
    chk("cfg_req_len", ddr.rd_req_len, 8'd0);
    wait_cond(0, "cfg_vld_timeout");
    chk("cfg_word_lit", cfg_word, 128'h7BEF5);
    chk("cfg_err_lit", err, 1'b0);

    // Single stream, three bursts
    clear_logs();
    req_vld = 4'b0001;
    wait_gnts(3, "single_gnt_timeout");
    req_vld = 4'b0000;
    wait_beats(0, 48, "single_beats_timeout");
    repeat (20) @(negedge clk);
    chk("single_hs_count", hs_log.size(), 3);
    for (int k = 0; k < 3; k++) begin
      chk("single_addr", (hs_log.size() > k) ? hs_log[k] : 32'hx, 32'h0801_0000 + 32'(k) * BB);
      chk("single_gnt", gnt_log[k], 4'b0001);
    end
    chk("single_beats", beats[0], 48);

    // Reset mid-burst, then restart
    req_vld = 4'b0001;
    wait_cond(2, "mid_data_timeout");
    @(posedge clk); #2 rst_n = 1'b0;
    #1 check_outputs_zero("midreset");
    req_vld = 4'b0000;
    @(posedge clk); #3 rst_n = 1'b1;
    pulse_start();
    @(negedge clk);
    chk("restart_req_valid", ddr.rd_req_valid, 1'b1);
    chk("restart_req_addr", ddr.rd_req_addr, 32'h0800_0000);
    wait_cond(0, "restart_cfg_timeout");

    // Contention
    clear_logs();
    req_vld = 4'b1111;
    wait_gnts(6, "contend_gnt_timeout");
    req_vld = 4'b0000;
    repeat (120) @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      chk("contend_gnt", gnt_log[k], exp_gnt[k]);
      chk("contend_addr", hs_log[k], exp_addr[k]);
    end

    // Backpressure
    clear_logs();
    hold_ready = 1'b1;
    req_vld = 4'b0100;
    wait_cond(1, "bp_valid_timeout");
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      req_vld = 4'($urandom_range(0, 15));
      chk("bp_addr", ddr.rd_req_addr, exp_f);
      chk("bp_len", ddr.rd_req_len, 8'd15);
      chk("bp_valid", ddr.rd_req_valid, 1'b1);
      chk("bp_no_gnt", req_gnt, 4'b0);
    end
    req_vld = 4'b0000;
    hold_ready = 1'b0;
    wait_gnts(1, "bp_gnt_timeout");
    chk("bp_gnt", gnt_log[0], 4'b0100);
    wait_beats(2, 16, "bp_beats_timeout");
    repeat (5) @(negedge clk);

    // Last-beat mismatch
    clear_logs();
    err_mode = 1;
    req_vld = 4'b0001;
    wait_gnts(1, "lastm_gnt_timeout");
    req_vld = 4'b0000;
    wait_cond(3, "lastm_err_timeout");
    repeat (10) @(negedge clk);
    chk("lastm_beats", beats[0], 10);
    chk("lastm_err", err, 1'b1);
    req_vld = 4'b0001;
    wait_gnts(2, "lastm_gnt2_timeout");
    req_vld = 4'b0000;
    wait_beats(0, 26, "lastm_beats2_timeout");
    repeat (5) @(negedge clk);
    chk("lastm_addr0", hs_log[0], exp_g0);
    chk("lastm_addr1", hs_log[1], exp_g1);
    chk("lastm_sticky", err, 1'b1);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      start = 1'b0;
      if ($urandom_range(0, 7) == 0) req_vld = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) err_mode = $urandom_range(1, 2);
      if ($urandom_range(0, 49) == 0) start = 1'b1;
      if (c == 1500) begin
        act_base    = 32'hFFFF_FF80;
        flgact_base = $urandom;
        wei_base    = $urandom;
        flgwei_base = $urandom;
        cfg_base    = $urandom;
        @(posedge clk); #2 rst_n = 1'b0;
        @(posedge clk); #3 rst_n = 1'b1;
        pulse_start();
      end
    end
    @(negedge clk);
    start = 1'b0;
    req_vld = 4'b0000;
    repeat (100) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ddr_rd_sched.md
Name: ddr_rd_sched

Overview:
- Read-side scheduler for the shared DDR image, which holds the CFG, ACT, FLGACT, WEI and FLGWEI regions at separate base addresses.
- After `start`, fetches the single layer-config word from CFG base.
- Then arbitrates four stream requesters (0=ACT, 1=FLGACT, 2=WEI, 3=FLGWEI) onto one burst read-request port, keeping one address cursor per region.
- Steers returned beats to the granted requester. Sits between the on-chip GBF fill logic and the AXI read master.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 128, read-data beat width (PORT_DATAWIDTH).
- BURST_LEN, 16, beats per stream burst (power of two, 1..256).
- LEN_WIDTH, 8, width of burst length field (beats-1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; samples base addresses, begins CFG fetch
- cfg_base  in  ADDR_WIDTH  CFG region byte address
- act_base  in  ADDR_WIDTH  ACT region base
- flgact_base  in  ADDR_WIDTH  FLGACT region base
- wei_base  in  ADDR_WIDTH  WEI region base
- flgwei_base  in  ADDR_WIDTH  FLGWEI region base
- req_vld  in  4  level request per stream
- req_gnt  out  4  one-hot pulse, burst for stream i accepted by DDR port
- rd_req_valid  out  1  burst request valid
- rd_req_ready  in  1  burst request accepted
- rd_req_addr  out  ADDR_WIDTH  burst start byte address
- rd_req_len  out  LEN_WIDTH  beats-1
- rd_data_valid  in  1  return beat valid (always accepted)
- rd_data  in  DATA_WIDTH  return beat
- rd_data_last  in  1  last beat marker
- out_vld  out  4  one-hot beat valid to stream i
- out_data  out  DATA_WIDTH  registered copy of rd_data
- cfg_word  out  DATA_WIDTH  latched config word
- cfg_vld  out  1  cfg_word valid
- busy  out  1  not IDLE
- err  out  1  sticky last-beat mismatch

Behaviour:
- Reset:
  - All outputs 0; state IDLE; cursors 0; RR pointer 0.
  - Asynchronous assert, synchronous deassert at the top level. Reset mid-burst abandons it; outstanding beats are not tracked.
- Burst size: BURST_BYTES = BURST_LEN*DATA_WIDTH/8.
- Addresses: cursor_i offsets from base_i; addr = base_i + cursor_i. Arithmetic is modulo 2^ADDR_WIDTH; wrap is silent.
- FSM:
  - IDLE: on start, latch bases, clear cursors, cfg_vld, err → CFG_REQ.
  - CFG_REQ: rd_req_valid=1, addr=cfg_base, len=0. On rd_req_ready → CFG_WAIT.
  - CFG_WAIT: first rd_data_valid loads cfg_word, sets cfg_vld next cycle → ARB. rd_data_last must be 1, else set err.
  - ARB: if any req_vld, select winner, register addr/len=BURST_LEN-1 → REQ. Else stay in ARB.
  - REQ: rd_req_valid=1; addr/len held stable until ready. On rd_req_ready: req_gnt[w] pulses 1 cycle, cursor_w += BURST_BYTES, beat counter cleared → DATA.
  - DATA:
    - Each rd_data_valid: out_vld[w]=1 and out_data=rd_data one cycle later; beat counter increments.
    - Burst ends when the counter reaches BURST_LEN → ARB.
    - If rd_data_last arrives before the final beat, or is absent on it: set err and end the burst at the earlier of the two events.
- Concurrency and ignored inputs:
  - Only one burst is outstanding.
  - start outside IDLE is ignored; re-issuing start requires a return to IDLE.
  - rd_data_valid in IDLE/CFG_REQ/ARB/REQ is ignored.
  - req_vld deassertion after a grant does not cancel the burst.
  - ARB→IDLE occurs only on reset; the layer sequencer resets or the block stays in ARB.
- busy=1 in all states except IDLE.

Optional Feature:
- Macro: DDR_RD_SCHED_RR_EN.
- Defined: round-robin arbitration. Search starts at (last winner+1) mod 4; pointer updates on each grant.
- Undefined: fixed priority, lowest index wins (ACT highest); no pointer register.

Test Plan:
- Reset: assert rst_n=0 mid-DATA → all outputs 0 immediately, state IDLE; after release, start restarts a CFG fetch at cfg_base.
- CFG fetch: start with cfg_base=0x0800_0000 → rd_req addr 0x0800_0000 len 0; beat 0x...7BEF5 with last=1 → cfg_word=0x...7BEF5, cfg_vld=1, err=0.
- Single stream: act_base=0x0801_0000, req_vld=4'b0001, defaults → bursts at 0x0801_0000, 0x0801_0100, 0x0801_0200 with len 15; 16 out_vld[0] pulses each; req_gnt[0] on each accept.
- Contention: req_vld=4'b1111 held → RR build grants 0,1,2,3,0,1; fixed build grants 0 every time; each cursor advances only on its own grant.
- Backpressure: rd_req_ready low 20 cycles in REQ while req_vld changes → rd_req_addr/len stable, no req_gnt until ready.
- Last mismatch: rd_data_last at beat 10 of 16 → err=1 sticky, burst ends, return to ARB; next burst address still base+cursor (cursor advanced).
